// File: rtl/fsm_pkg.sv
// Shared master/slave load-FSM encodings. Imported by the FSM and by
// fsm_flag_gen so both sides agree on state codes.
package fsm_pkg;

  localparam int MAST_FSM_BITS = 3;
  localparam int SLAV_FSM_BITS = 3;

  typedef enum logic [MAST_FSM_BITS-1:0] {
    M_IDLE = 3'd0,
    LEFT   = 3'd1,
    BASE   = 3'd2,
    RIGHT  = 3'd3,
    FSLD   = 3'd7
  } mast_state_e;

  typedef enum logic [SLAV_FSM_BITS-1:0] {
    S_IDLE = 3'd0,
    TOP    = 3'd1,
    MID    = 3'd2,
    BOTT   = 3'd3
  } slav_state_e;

  function automatic logic mast_legal(input logic [MAST_FSM_BITS-1:0] s);
    return (s == M_IDLE) || (s == LEFT) || (s == BASE) || (s == RIGHT) || (s == FSLD);
  endfunction

  function automatic logic slav_legal(input logic [SLAV_FSM_BITS-1:0] s);
    return (s == S_IDLE) || (s == TOP) || (s == MID) || (s == BOTT);
  endfunction

  // Slave states in which a data beat can be consumed.
  function automatic logic slav_active(input logic [SLAV_FSM_BITS-1:0] s);
    return (s == TOP) || (s == MID) || (s == BOTT);
  endfunction

endpackage

// File: rtl/fsm_flag_gen_if.sv
// Handshake bundle between the load FSM (master side) and the flag
// generator (slave side): FSM states and input beat handshake in,
// completion flags and SRAM position out.
interface fsm_flag_gen_if import fsm_pkg::*; #(
  parameter int CNT_BITS = 9
) ();
  logic [MAST_FSM_BITS-1:0] mast_state;
  logic [SLAV_FSM_BITS-1:0] slav_state;
  logic                     in_valid;
  logic                     in_ready;
  logic                     sl_top_done;
  logic                     sl_mid_done;
  logic                     sl_bott_done;
  logic                     flag_fsld_end;
  logic                     flag_base_end;
  logic [CNT_BITS-1:0]      now_of_row;
  logic [CNT_BITS-1:0]      col_cnt;

  modport master (
    output mast_state, slav_state, in_valid,
    input  in_ready, sl_top_done, sl_mid_done, sl_bott_done,
           flag_fsld_end, flag_base_end, now_of_row, col_cnt
  );

  modport slave (
    input  mast_state, slav_state, in_valid,
    output in_ready, sl_top_done, sl_mid_done, sl_bott_done,
           flag_fsld_end, flag_base_end, now_of_row, col_cnt
  );
endinterface

// File: rtl/wrap_cnt.sv
// Up counter that wraps to 0 after LIMIT-1. clr has priority over inc,
// so a wrap and a clear in the same cycle land on 0 either way.
module wrap_cnt #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == WIDTH'(LIMIT-1));
  assign cnt  = cnt_q;

  // Next count: clear beats increment; increment wraps at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fsm_flag_gen.sv
// Flag generator for the load FSM. Counts accepted beats and raises the
// zero-bubble (Mealy) completion flags the FSM consumes; exports row and
// column position for SRAM addressing.
// Optional: define FSM_FLAG_GEN_ERRCHK_EN to add a sticky protocol err output.
module fsm_flag_gen import fsm_pkg::*; #(
  parameter int FSLD_BEATS = 64,
  parameter int ROW_BEATS  = 16,
  parameter int MID_ROWS   = 8,
  parameter int BASE_COLS  = 4,
  parameter int CNT_BITS   = 9
) (
  input  logic           clk,
  input  logic           reset,
  fsm_flag_gen_if.slave  bus
`ifdef FSM_FLAG_GEN_ERRCHK_EN
  ,
  output logic           err
`endif
);
  localparam int BEAT_MAX = (FSLD_BEATS > ROW_BEATS) ? FSLD_BEATS : ROW_BEATS;
  localparam int BEAT_W   = (BEAT_MAX > 1) ? $clog2(BEAT_MAX) : 1;

  logic              m_legal, s_legal, s_act;
  logic              m_idle, m_fsld, m_base;
  logic              ready, acc;
  logic              fsld_last, row_last, row_end;
  logic              top_done, mid_done, bott_done, fsld_end;
  logic              beat_clr, row_inc, row_clr;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_BITS-1:0] row_q;
  logic [CNT_BITS-1:0] col_q, col_d;
  logic              col_at_end;
  logic              beat_last_unused, row_last_unused;

  // State decode; unknown master codes behave as M_IDLE.
  always_comb begin
    m_legal = mast_legal(bus.mast_state);
    s_legal = slav_legal(bus.slav_state);
    s_act   = slav_active(bus.slav_state);
    m_idle  = (bus.mast_state == M_IDLE) || !m_legal;
    m_fsld  = (bus.mast_state == FSLD);
    m_base  = (bus.mast_state == BASE);
  end

  assign ready = !reset && m_legal && s_legal && (m_fsld || s_act);
  assign acc   = bus.in_valid && ready;

  assign fsld_last = (beat_cnt == BEAT_W'(FSLD_BEATS-1));
  assign row_last  = (beat_cnt == BEAT_W'(ROW_BEATS-1));
  assign fsld_end  = acc && m_fsld && fsld_last;
  assign row_end   = acc && !m_fsld && row_last;
  assign top_done  = row_end && (bus.slav_state == TOP);
  assign mid_done  = row_end && (bus.slav_state == MID) && (row_q == CNT_BITS'(MID_ROWS));
  assign bott_done = row_end && (bus.slav_state == BOTT);

  // Beat counter wraps via clr at the end of a row or of preload, so one
  // instance serves both beat limits.
  assign beat_clr = reset || m_idle || (!s_act && !m_fsld) || fsld_end || row_end;

  wrap_cnt #(.WIDTH(BEAT_W), .LIMIT(BEAT_MAX)) u_beat (
    .clk (clk),
    .inc (acc),
    .clr (beat_clr),
    .cnt (beat_cnt),
    .last(beat_last_unused)
  );

  // Row index: TOP row ends at 0->1, MID walks 1..MID_ROWS, the final MID
  // row lifts it to MID_ROWS+1 for BOTT, and BOTT completion rewinds it.
  assign row_inc = row_end && ((bus.slav_state == TOP) || (bus.slav_state == MID));
  assign row_clr = reset || m_idle || bott_done;

  wrap_cnt #(.WIDTH(CNT_BITS), .LIMIT(MID_ROWS+2)) u_row (
    .clk (clk),
    .inc (row_inc),
    .clr (row_clr),
    .cnt (row_q),
    .last(row_last_unused)
  );

  assign col_at_end = (col_q == CNT_BITS'(BASE_COLS-1));

  // BASE strip counter: advances per finished BASE strip, saturating.
  always_comb begin
    col_d = col_q;
    if (reset || m_idle)                         col_d = '0;
    else if (bott_done && m_base && !col_at_end) col_d = col_q + 1'b1;
  end

  // Strip counter register.
  always_ff @(posedge clk) begin
    col_q <= col_d;
  end

  assign bus.in_ready      = ready;
  assign bus.flag_fsld_end = fsld_end;
  assign bus.sl_top_done   = top_done;
  assign bus.sl_mid_done   = mid_done;
  assign bus.sl_bott_done  = bott_done;
  // Level from the registered strip count, valid for the whole last strip.
  assign bus.flag_base_end = !reset && m_base && col_at_end;
  assign bus.now_of_row    = reset ? '0 : row_q;
  assign bus.col_cnt       = reset ? '0 : col_q;

`ifdef FSM_FLAG_GEN_ERRCHK_EN
  logic err_q, err_d;

  // Sticky protocol error: dropped beat outside idle, bad state code, or
  // RIGHT finishing before all BASE strips were done.
  always_comb begin
    err_d = err_q;
    if (reset) err_d = 1'b0;
    else if ((bus.in_valid && !ready && (bus.mast_state != M_IDLE)) ||
             !m_legal || !s_legal ||
             (bott_done && (bus.mast_state == RIGHT) && !col_at_end))
      err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    err_q <= err_d;
  end

  assign err = err_q && !reset;
`endif

endmodule

// File: tb/tb_fsm_flag_gen.sv
// Bench for fsm_flag_gen: a behavioural load-FSM partner steers the
// state inputs from the bench's own expected flags; a scoreboard queue
// holds expected outputs per driven cycle, compared mid-cycle.
module tb_fsm_flag_gen;
  import fsm_pkg::*;

  localparam int FSLD_BEATS = 4;
  localparam int ROW_BEATS  = 3;
  localparam int MID_ROWS   = 2;
  localparam int BASE_COLS  = 2;
  localparam int CNT_BITS   = 9;

  logic clk = 1'b0;
  logic reset;
`ifdef FSM_FLAG_GEN_ERRCHK_EN
  logic err;
`endif

  always #5 clk = ~clk;

  fsm_flag_gen_if #(.CNT_BITS(CNT_BITS)) bus ();

  fsm_flag_gen #(
    .FSLD_BEATS(FSLD_BEATS), .ROW_BEATS(ROW_BEATS), .MID_ROWS(MID_ROWS),
    .BASE_COLS(BASE_COLS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef FSM_FLAG_GEN_ERRCHK_EN
    ,
    .err  (err)
`endif
  );

  typedef struct {
    logic rdy, top, mid, bott, fend, bend, err;
    int   row, col;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_err = 0;

  // partner FSM + expected-counter model
  logic [2:0] fm, fs;
  int mb, mr, mc;
  logic merr, run_done;
  // last DUT samples and pulse counters
  logic s_top, s_mid, s_rdy;
  int   s_row;
  int   n_fend, n_top, n_mid, n_bott, n_nrdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic mleg(input logic [2:0] s);
    return s == M_IDLE || s == LEFT || s == BASE || s == RIGHT || s == FSLD;
  endfunction

  function automatic logic sact(input logic [2:0] s);
    return s == TOP || s == MID || s == BOTT;
  endfunction

  task automatic step(input logic vld, input logic rst);
    exp_t e, o;
    logic ml, sl, sa, midl, acc, rend, eb;
    reset          = rst;
    bus.in_valid   = vld;
    bus.mast_state = fm;
    bus.slav_state = fs;
    ml   = mleg(fm);
    sa   = sact(fs);
    sl   = sa || fs == S_IDLE;
    midl = (fm == M_IDLE) || !ml;
    e.rdy  = !rst && ml && sl && (fm == FSLD || sa);
    acc    = vld && e.rdy;
    e.fend = acc && fm == FSLD && mb == FSLD_BEATS-1;
    rend   = acc && fm != FSLD && mb == ROW_BEATS-1;
    e.top  = rend && fs == TOP;
    e.mid  = rend && fs == MID && mr == MID_ROWS;
    e.bott = rend && fs == BOTT;
    e.bend = !rst && fm == BASE && mc == BASE_COLS-1;
    e.row  = rst ? 0 : mr;
    e.col  = rst ? 0 : mc;
    e.err  = !rst && merr;
    sbq.push_back(e);
    #3;
    o = sbq.pop_front();
    chk("in_ready",      bus.in_ready,      o.rdy);
    chk("flag_fsld_end", bus.flag_fsld_end, o.fend);
    chk("sl_top_done",   bus.sl_top_done,   o.top);
    chk("sl_mid_done",   bus.sl_mid_done,   o.mid);
    chk("sl_bott_done",  bus.sl_bott_done,  o.bott);
    chk("flag_base_end", bus.flag_base_end, o.bend);
    chk("now_of_row",    32'(bus.now_of_row), o.row);
    chk("col_cnt",       32'(bus.col_cnt),    o.col);
`ifdef FSM_FLAG_GEN_ERRCHK_EN
    chk("err", err, o.err);
`endif
    s_top = bus.sl_top_done; s_mid = bus.sl_mid_done;
    s_rdy = bus.in_ready;    s_row = 32'(bus.now_of_row);
    n_fend += int'(bus.flag_fsld_end); n_top += int'(bus.sl_top_done);
    n_mid  += int'(bus.sl_mid_done);   n_bott += int'(bus.sl_bott_done);
    if (fm != M_IDLE && !bus.in_ready) n_nrdy++;
    // model next state
    eb = e.bott;
    if (rst) merr = 1'b0;
    else if ((vld && !e.rdy && fm != M_IDLE) || !ml || !sl ||
             (eb && fm == RIGHT && mc != BASE_COLS-1)) merr = 1'b1;
    if (rst || midl || (!sa && fm != FSLD) || e.fend || rend) mb = 0;
    else if (acc) mb++;
    if (rst || midl || eb) mr = 0;
    else if (rend && (fs == TOP || fs == MID)) mr++;
    if (rst || midl) mc = 0;
    else if (eb && fm == BASE && mc < BASE_COLS-1) mc++;
    if (rst) begin
      fm = M_IDLE; fs = S_IDLE;
    end else if (fm == FSLD) begin
      if (e.fend) begin fm = LEFT; fs = S_IDLE; end
    end else if (fm == LEFT || fm == BASE || fm == RIGHT) begin
      if (fs == S_IDLE) fs = TOP;
      else if (e.top) fs = MID;
      else if (e.mid) fs = BOTT;
      else if (eb) begin
        if (fm == LEFT) fm = BASE;
        else if (fm == BASE) begin if (e.bend) fm = RIGHT; end
        else begin fm = M_IDLE; run_done = 1'b1; end
        fs = (fm == M_IDLE) ? S_IDLE : TOP;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gap [5];
    int k;
    gap = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fm = M_IDLE; fs = S_IDLE; mb = 0; mr = 0; mc = 0;
    merr = 1'b0; run_done = 1'b0;
    n_fend = 0; n_top = 0; n_mid = 0; n_bott = 0; n_nrdy = 0;
    reset = 1'b1; bus.in_valid = 1'b0;
    bus.mast_state = M_IDLE; bus.slav_state = S_IDLE;
    @(posedge clk); #1;

    // reset with beats offered: everything reads 0
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // full preload + LEFT, two BASE strips, RIGHT, with in_valid held high
    n_fend = 0; n_top = 0; n_mid = 0; n_bott = 0; n_nrdy = 0;
    fm = FSLD;
    k = 0;
    while (!run_done && k < 200) begin step(1'b1, 1'b0); k++; end
    chk("run_done", run_done, 1'b1);
    chk("n_fsld_end", n_fend, 1);
    chk("n_top_done", n_top, 4);
    chk("n_mid_done", n_mid, 4);
    chk("n_bott_done", n_bott, 4);
    chk("n_ready_gap", n_nrdy, 1);
`ifdef FSM_FLAG_GEN_ERRCHK_EN
    chk("err_sticky", err, 1'b1);
`endif
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // gapped input during TOP
    fm = FSLD;
    k = 0;
    while (!(fm == LEFT && fs == TOP) && k < 20) begin step(1'b1, 1'b0); k++; end
    chk("reach_top", fm == LEFT && fs == TOP, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(gap[i], 1'b0);
      chk($sformatf("gap_top%0d", i), s_top, (i == 4));
    end

    // reset in MID with now_of_row=1, beat_cnt=2
    k = 0;
    while (!(fs == MID && mb == 2 && mr == 1) && k < 20) begin step(1'b1, 1'b0); k++; end
    chk("reach_mid", fs == MID && mb == 2 && mr == 1, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_mid_done", s_mid, 1'b0);
    chk("rst_ready", s_rdy, 1'b0);
    step(1'b1, 1'b0);
    chk("post_rst_row", s_row, 0);
    chk("post_rst_ready", s_rdy, 1'b0);

    // unknown state codes behave as idle
    fm = LEFT; fs = 3'd5;
    step(1'b1, 1'b0);
    fm = 3'd5; fs = TOP;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
